// File: rtl/bcd_arbiter.sv
// bcd_arbiter: round-robin sequencer sharing one bcd_encoder among NUM_REQ requesters.
// Define BCD_ARB_TIMEOUT_EN to enable the BUSY watchdog (rsp_error on timeout).
module bcd_arbiter #(
  parameter int BINARY_LENGTH  = 128,
  parameter int DECIMAL_LENGTH = 39,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*BINARY_LENGTH-1:0] req_data,
  output logic [NUM_REQ-1:0]               rsp_valid,
  input  logic [NUM_REQ-1:0]               rsp_ready,
  output logic [DECIMAL_LENGTH*4-1:0]      rsp_bcd,
  output logic                             rsp_error,
  output logic [BINARY_LENGTH-1:0]         enc_binary,
  output logic                             enc_start,
  input  logic [DECIMAL_LENGTH*4-1:0]      enc_bcd,
  input  logic                             enc_ready
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int RW = DECIMAL_LENGTH * 4;
  localparam logic [OW-1:0] LAST = OW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SETTLE,
    S_BUSY,
    S_RESP
  } state_e;

  state_e                   state_q;
  logic [OW-1:0]            rr_ptr_q;
  logic [OW-1:0]            owner_q;
  logic [NUM_REQ-1:0]       rsp_valid_q;
  logic [RW-1:0]            rsp_bcd_q;
  logic [BINARY_LENGTH-1:0] enc_binary_q;
  logic                     enc_start_q;

  logic [OW-1:0] win_d;
  logic [OW-1:0] scan_d;
  logic          found_d;

  // Scan from rr_ptr upward; explicit wrap keeps non-power-of-two counts correct.
  always_comb begin
    win_d   = rr_ptr_q;
    scan_d  = rr_ptr_q;
    found_d = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found_d && req_valid[scan_d]) begin
        found_d = 1'b1;
        win_d   = scan_d;
      end
      scan_d = (scan_d == LAST) ? '0 : scan_d + 1'b1;
    end
  end

  assign req_ready = (state_q == S_IDLE && found_d) ? (ONE << win_d) : '0;

`ifdef BCD_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] tmo_q;
  logic          rsp_error_q;
  logic          tmo_hit;
  assign tmo_hit   = (tmo_q == CW'(TIMEOUT_CYCLES - 1));
  assign rsp_error = rsp_error_q;
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES != 0);
  assign rsp_error  = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_bcd_q    <= '0;
      enc_binary_q <= '0;
      enc_start_q  <= 1'b0;
`ifdef BCD_ARB_TIMEOUT_EN
      tmo_q        <= '0;
      rsp_error_q  <= 1'b0;
`endif
    end else begin
      enc_start_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (found_d) begin
            enc_binary_q <=
              req_data[int'(win_d)*BINARY_LENGTH +: BINARY_LENGTH];
            owner_q      <= win_d;
            enc_start_q  <= 1'b1;
            state_q      <= S_START;
          end
        end
        S_START: state_q <= S_SETTLE;
        // enc_ready may still show the previous result here
        S_SETTLE: begin
          state_q <= S_BUSY;
`ifdef BCD_ARB_TIMEOUT_EN
          tmo_q   <= '0;
`endif
        end
        S_BUSY: begin
          if (enc_ready) begin
            rsp_bcd_q   <= enc_bcd;
            rsp_valid_q <= ONE << owner_q;
            state_q     <= S_RESP;
`ifdef BCD_ARB_TIMEOUT_EN
            rsp_error_q <= 1'b0;
          end else if (tmo_hit) begin
            rsp_bcd_q   <= '0;
            rsp_error_q <= 1'b1;
            rsp_valid_q <= ONE << owner_q;
            state_q     <= S_RESP;
          end else begin
            tmo_q <= tmo_q + 1'b1;
`endif
          end
        end
        S_RESP: begin
          if (rsp_ready[owner_q]) begin
            rsp_valid_q <= '0;
            rr_ptr_q    <= (owner_q == LAST) ? '0 : owner_q + 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_bcd    = rsp_bcd_q;
  assign enc_binary = enc_binary_q;
  assign enc_start  = enc_start_q;

endmodule

// File: tb/tb_bcd_arbiter.sv
// tb_bcd_arbiter: directed and randomized checks of bcd_arbiter
// against a latency-configurable encoder model and an arbitration scoreboard.
module tb_bcd_arbiter;

  localparam int BL  = 128;
  localparam int DL  = 39;
  localparam int RW  = DL * 4;
  localparam int N   = 4;
  localparam int TMO = 16;

  logic          CLK       = 1'b0;
  logic          RST       = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [N*BL-1:0] req_data = '0;
  logic [N-1:0]  rsp_valid;
  logic [N-1:0]  rsp_ready = '0;
  logic [RW-1:0] rsp_bcd;
  logic          rsp_error;
  logic [BL-1:0] enc_binary;
  logic          enc_start;
  logic [RW-1:0] enc_bcd;
  logic          enc_ready;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  int            enc_lat   = 10;
  bit            enc_stuck = 1'b0;
  int            enc_cnt   = 0;
  bit            enc_stale = 1'b0;
  logic [RW-1:0] enc_res   = '0;

  bcd_arbiter #(
    .BINARY_LENGTH (BL),
    .DECIMAL_LENGTH(DL),
    .NUM_REQ       (N),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_bcd   (rsp_bcd),
    .rsp_error (rsp_error),
    .enc_binary(enc_binary),
    .enc_start (enc_start),
    .enc_bcd   (enc_bcd),
    .enc_ready (enc_ready)
  );

  always #5 CLK = ~CLK;

  function automatic logic [RW-1:0] ref_bcd(input logic [BL-1:0] v);
    logic [BL-1:0] x;
    logic [RW-1:0] r;
    x = v;
    r = '0;
    for (int i = 0; i < DL; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [BL-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] one;
    one = 1;
    return one << i;
  endfunction

  // Encoder: ready (level) in cycle start+L; it keeps showing the old
  // result one cycle past the start pulse, like a slow ready clear.
  always @(posedge CLK) begin
    enc_stale <= enc_start;
    if (enc_start) begin
      enc_cnt <= enc_lat - 1;
    end else if (enc_cnt > 0) begin
      enc_cnt <= enc_cnt - 1;
      if (enc_cnt == 1) enc_res <= ref_bcd(enc_binary);
    end
  end
  assign enc_ready = !enc_stuck && (enc_stale || enc_cnt == 0);
  assign enc_bcd   = enc_res;

  task automatic tick();
    @(posedge CLK);
    #2;
    cyc++;
  endtask

  task automatic set_data(input int i, input logic [BL-1:0] v);
    req_data[i*BL +: BL] = v;
  endtask

  task automatic do_reset();
    RST       = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    enc_stuck = 1'b0;
    enc_lat   = 10;
    tick();
    tick();
    RST = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    RST       = 1'b1;
    req_valid = '0;
    tick();
    tick();
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_error, enc_start} !== '0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got rdy=%b rv=%b err=%b st=%b want all 0",
               req_ready, rsp_valid, rsp_error, enc_start);
    end
    n_cmp++;
    if (rsp_bcd !== '0 || enc_binary !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got bcd=%h bin=%h want 0", rsp_bcd, enc_binary);
    end
  endtask

  task automatic test_single();
    do_reset();
    rsp_ready = '1;
    set_data(0, BL'(54));
    req_valid = 4'b0001;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL single_grant: got %b want 0001", req_ready);
    end
    tick();
    req_valid = '0;
    #1;
    n_cmp++;
    if (enc_start !== 1'b1 || enc_binary !== BL'(54)) begin
      n_bad++;
      $display("FAIL single_start: got st=%b bin=%0d want 1/54", enc_start, enc_binary);
    end
    for (int c = 2; c < 12; c++) begin
      tick();
      #1;
      n_cmp++;
      if (rsp_valid !== '0 || enc_start !== 1'b0) begin
        n_bad++;
        $display("FAIL single_wait c%0d: got rv=%b st=%b want 0", c, rsp_valid, enc_start);
      end
    end
    tick();
    #1;
    n_cmp++;
    if (rsp_valid !== 4'b0001 || rsp_bcd !== RW'('h54) || rsp_error !== 1'b0) begin
      n_bad++;
      $display("FAIL single_rsp c12: got rv=%b bcd=%h err=%b want 0001/54/0",
               rsp_valid, rsp_bcd, rsp_error);
    end
    tick();
    #1;
    n_cmp++;
    if (rsp_valid !== '0) begin
      n_bad++;
      $display("FAIL single_rsp_drop: got %b want 0", rsp_valid);
    end
  endtask

  task automatic test_two_req();
    int           exp_o [2];
    logic [RW-1:0] exp_b [2];
    logic [N-1:0] clr;
    int           ng;
    int           nr;
    exp_o = '{0, 2};
    exp_b = '{RW'('h7), RW'('h999)};
    do_reset();
    rsp_ready = '1;
    set_data(0, BL'(7));
    set_data(2, BL'(999));
    req_valid = 4'b0101;
    clr = '0;
    ng  = 0;
    nr  = 0;
    for (int t = 0; t < 200 && nr < 2; t++) begin
      if (t > 0) tick();
      req_valid &= ~clr;
      clr = '0;
      #1;
      if (req_ready !== '0) begin
        n_cmp++;
        if (ng >= 2 || req_ready !== oh(exp_o[ng])) begin
          n_bad++;
          $display("FAIL two_grant #%0d: got %b", ng, req_ready);
        end
        clr = req_ready;
        ng++;
      end
      if (rsp_valid !== '0) begin
        n_cmp++;
        if (nr >= 2 || rsp_valid !== oh(exp_o[nr]) || rsp_bcd !== exp_b[nr]) begin
          n_bad++;
          $display("FAIL two_rsp #%0d: got rv=%b bcd=%h", nr, rsp_valid, rsp_bcd);
        end
        nr++;
      end
    end
    n_cmp++;
    if (nr != 2) begin
      n_bad++;
      $display("FAIL two_count: got %0d responses want 2", nr);
    end
    tick();
    set_data(0, rnd128());
    set_data(3, rnd128());
    req_valid = 4'b1001;
    #1;
    n_cmp++;
    if (req_ready !== 4'b1000) begin
      n_bad++;
      $display("FAIL two_rr_ptr3: got %b want 1000", req_ready);
    end
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    logic [BL-1:0] data [N];
    logic [BL-1:0] op;
    int            ng;
    int            own;
    int            refresh;
    bit            busy;
    do_reset();
    rsp_ready = '1;
    for (int i = 0; i < N; i++) begin
      data[i] = rnd128();
      set_data(i, data[i]);
    end
    req_valid = '1;
    ng = 0; own = 0; refresh = -1; busy = 1'b0; op = '0;
    for (int t = 0; t < 300 && ng < 6; t++) begin
      if (t > 0) tick();
      if (refresh >= 0) begin
        data[refresh] = rnd128();
        set_data(refresh, data[refresh]);
        refresh = -1;
      end
      #1;
      if (!busy) begin
        n_cmp++;
        if (req_ready !== oh(ng % N)) begin
          n_bad++;
          $display("FAIL rr_grant #%0d: got %b want %b", ng, req_ready, oh(ng % N));
        end
        own = ng % N;
        op = data[own];
        refresh = own;
        busy = 1'b1;
        ng++;
      end else begin
        n_cmp++;
        if (req_ready !== '0) begin
          n_bad++;
          $display("FAIL rr_ready_busy c%0d: got %b want 0", cyc, req_ready);
        end
        if (rsp_valid !== '0) begin
          n_cmp++;
          if (rsp_valid !== oh(own) || rsp_bcd !== ref_bcd(op)) begin
            n_bad++;
            $display("FAIL rr_rsp: got rv=%b bcd=%h want %b/%h",
                     rsp_valid, rsp_bcd, oh(own), ref_bcd(op));
          end
          busy = 1'b0;
        end
      end
    end
    n_cmp++;
    if (ng < 6) begin
      n_bad++;
      $display("FAIL rr_count: got %0d grants want 6", ng);
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [BL-1:0] v;
    int            w;
    do_reset();
    v = rnd128();
    set_data(1, v);
    req_valid = 4'b0010;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_bad++;
      $display("FAIL bp_grant: got %b want 0010", req_ready);
    end
    tick();
    set_data(0, rnd128());
    set_data(2, rnd128());
    req_valid = 4'b0101;
    for (w = 0; w < 40; w++) begin
      #1;
      if (rsp_valid !== '0) break;
      tick();
    end
    n_cmp++;
    if (rsp_valid !== 4'b0010 || rsp_bcd !== ref_bcd(v)) begin
      n_bad++;
      $display("FAIL bp_rsp: got rv=%b bcd=%h want 0010/%h", rsp_valid, rsp_bcd, ref_bcd(v));
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      rsp_ready = 4'b1101;
      #1;
      n_cmp++;
      if (rsp_valid !== 4'b0010 || rsp_bcd !== ref_bcd(v) ||
          req_ready !== '0 || enc_start !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold k%0d: got rv=%b rdy=%b st=%b bcd=%h",
                 k, rsp_valid, req_ready, enc_start, rsp_bcd);
      end
    end
    tick();
    rsp_ready = 4'b0010;
    #1;
    tick();
    rsp_ready = '0;
    #1;
    n_cmp++;
    if (rsp_valid !== '0 || req_ready !== 4'b0100) begin
      n_bad++;
      $display("FAIL bp_next: got rv=%b rdy=%b want 0000/0100", rsp_valid, req_ready);
    end
    req_valid = '0;
  endtask

  task automatic test_reset_busy();
    int seen;
    do_reset();
    rsp_ready = '1;
    set_data(0, rnd128());
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    repeat (4) tick();
    RST = 1'b1;
    tick();
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_bcd, rsp_error, enc_binary, enc_start} !== '0) begin
      n_bad++;
      $display("FAIL rstbusy_zero: got rdy=%b rv=%b err=%b st=%b bin=%h bcd=%h",
               req_ready, rsp_valid, rsp_error, enc_start, enc_binary, rsp_bcd);
    end
    RST  = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      #1;
      if (rsp_valid !== '0 || enc_start !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL rstbusy_abort: got %0d active cycles want 0", seen);
    end
    set_data(0, BL'(123));
    req_valid = 4'b0001;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL rstbusy_regrant: got %b want 0001", req_ready);
    end
    tick();
    req_valid = '0;
    seen = 0;
    for (int c = 1; c < 12; c++) begin
      #1;
      if (rsp_valid !== '0) seen++;
      tick();
    end
    #1;
    n_cmp++;
    if (seen != 0 || rsp_valid !== 4'b0001 || rsp_bcd !== RW'('h123)) begin
      n_bad++;
      $display("FAIL rstbusy_rsp: got early=%0d rv=%b bcd=%h want 0/0001/123",
               seen, rsp_valid, rsp_bcd);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    rsp_ready = '1;
    enc_stuck = 1'b1;
    set_data(0, rnd128());
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
`ifdef BCD_ARB_TIMEOUT_EN
    begin
      int first;
      first = -1;
      for (int c = 1; c <= 40; c++) begin
        #1;
        if (rsp_valid !== '0) begin
          first = cyc;
          n_cmp++;
          if (rsp_valid !== 4'b0001 || rsp_error !== 1'b1 || rsp_bcd !== '0) begin
            n_bad++;
            $display("FAIL tmo_rsp: got rv=%b err=%b bcd=%h want 0001/1/0",
                     rsp_valid, rsp_error, rsp_bcd);
          end
          break;
        end
        tick();
      end
      n_cmp++;
      if (first != 3 + TMO) begin
        n_bad++;
        $display("FAIL tmo_cycle: got %0d want %0d", first, 3 + TMO);
      end
    end
`else
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 1000; c++) begin
        #1;
        if (rsp_valid !== '0 || rsp_error !== 1'b0) seen++;
        tick();
      end
      n_cmp++;
      if (seen != 0) begin
        n_bad++;
        $display("FAIL tmo_none: got %0d response cycles want 0", seen);
      end
    end
`endif
    enc_stuck = 1'b0;
  endtask

  task automatic test_random();
    logic [BL-1:0] data [N];
    logic [BL-1:0] op;
    logic [N-1:0]  clr;
    logic [N-1:0]  exp_rdy;
    logic [N-1:0]  exp_rv;
    bit            exp_st;
    bit            busy;
    int            rr, own, g, lat, w, j;
    do_reset();
    busy = 1'b0; rr = 0; own = 0; g = 0; lat = 10; clr = '0; op = '0;
    for (int i = 0; i < N; i++) data[i] = '0;
    for (int t = 0; t < 2500; t++) begin
      if (t > 0) tick();
      req_valid &= ~clr;
      clr = '0;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          data[i] = rnd128();
          set_data(i, data[i]);
          req_valid[i] = 1'b1;
        end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = N'($urandom());
      #1;
      w = -1;
      if (!busy) begin
        for (int k = 0; k < N; k++) begin
          j = (rr + k) % N;
          if (w < 0 && req_valid[j]) w = j;
        end
      end
      exp_rdy = (w >= 0) ? oh(w) : '0;
      exp_st  = busy && (cyc == g + 1);
      exp_rv  = (busy && cyc >= g + 2 + lat) ? oh(own) : '0;
      n_cmp++;
      if ({req_ready, rsp_valid, enc_start} !== {exp_rdy, exp_rv, exp_st}) begin
        n_bad++;
        $display("FAIL rand_ctrl c%0d: got rdy=%b rv=%b st=%b want %b/%b/%b",
                 cyc, req_ready, rsp_valid, enc_start, exp_rdy, exp_rv, exp_st);
      end
      if (exp_rv != '0) begin
        n_cmp++;
        if (rsp_bcd !== ref_bcd(op) || rsp_error !== 1'b0) begin
          n_bad++;
          $display("FAIL rand_data c%0d: got bcd=%h err=%b want %h/0",
                   cyc, rsp_bcd, rsp_error, ref_bcd(op));
        end
        if (rsp_ready[own]) begin
          busy = 1'b0;
          rr = (own + 1) % N;
        end
      end
      if (w >= 0) begin
        busy    = 1'b1;
        own     = w;
        op      = data[w];
        g       = cyc;
        lat     = $urandom_range(2, 12);
        enc_lat = lat;
        clr     = exp_rdy;
      end
    end
    req_valid = '0;
    rsp_ready = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_req();
    test_round_robin();
    test_backpressure();
    test_reset_busy();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
